// File: rtl/es_mem_req.sv
// EX-stage memory request issue: holds the EX pipeline register for loads/stores,
// drives sram-like req/addr_ok, and flags address errors (ES_ADDR_EXC_EN).
module es_mem_req #(
  parameter logic [4:0] EXC_ADEL = 5'h04,
  parameter logic [4:0] EXC_ADES = 5'h05
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_rt,
  input  logic [6:0]  in_ld_op,
  input  logic [4:0]  in_st_op,
  input  logic        in_ex,
  input  logic [4:0]  in_excode,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_addr,
  output logic [6:0]  out_ld_op,
  output logic        out_store_op,
  output logic        out_ex,
  output logic [4:0]  out_excode,
  output logic [31:0] out_badvaddr,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        flush
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, CANCEL} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [6:0]  ld_op;   // {lw,lb,lbu,lh,lhu,lwl,lwr}
    logic [4:0]  st_op;   // {sw,sb,sh,swl,swr}
    logic        ex;
    logic [4:0]  excode;
  } es_reg_t;

  es_reg_t r;
  logic    es_valid;
  state_t  state, state_nxt;

  logic mem_op, is_store, is_word, is_half, is_byte;
  logic addr_err, ex, ready_go;
  logic [1:0] pos;

  assign is_store = |r.st_op;
  assign mem_op   = |r.ld_op || is_store;
  assign is_word  = r.ld_op[6] | r.st_op[4];
  assign is_half  = r.ld_op[3] | r.ld_op[2] | r.st_op[2];
  assign is_byte  = r.ld_op[5] | r.ld_op[4] | r.st_op[3];
  assign pos      = r.addr[1:0];

`ifdef ES_ADDR_EXC_EN
  assign addr_err = (is_word && (r.addr[1:0] != 2'b00)) || (is_half && r.addr[0]);
`else
  assign addr_err = 1'b0;
`endif

  assign ex             = es_valid && (r.ex || addr_err);
  assign ready_go       = !mem_op || ex || state == DONE;
  assign es_to_ms_valid = es_valid && ready_go && !flush;
  assign es_allowin     = (!es_valid || (ready_go && ms_allowin)) && state != CANCEL;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid <= 1'b0;
      r        <= '0;
    end else begin
      if (flush)           es_valid <= 1'b0;
      else if (es_allowin) es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) begin
        r.pc     <= in_pc;
        r.addr   <= in_addr;
        r.rt     <= in_rt;
        r.ld_op  <= in_ld_op;
        r.st_op  <= in_st_op;
        r.ex     <= in_ex;
        r.excode <= in_excode;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // A request already on the bus must finish its address phase even after a
  // flush; CANCEL keeps it alive and blocks new instructions until addr_ok.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (es_valid && mem_op && !ex && !flush && ms_allowin) state_nxt = REQ;
      REQ:    if (data_sram_addr_ok) state_nxt = flush ? IDLE : DONE;
              else if (flush)        state_nxt = CANCEL;
      DONE:   if ((es_to_ms_valid && ms_allowin) || flush) state_nxt = IDLE;
      CANCEL: if (data_sram_addr_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_sram_req = (state == REQ) || (state == CANCEL);
  end

  // Request encoding comes straight from the held register, so it stays
  // constant for as long as req is up.
  always_comb begin
    data_sram_size  = 2'd2;
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = 32'h0;
    data_sram_addr  = {r.addr[31:2], 2'b00};
    if (is_byte) begin
      data_sram_size  = 2'd0;
      data_sram_addr  = r.addr;
      data_sram_wstrb = 4'b0001 << pos;
      data_sram_wdata = {4{r.rt[7:0]}};
    end else if (is_half) begin
      data_sram_size  = 2'd1;
      data_sram_addr  = {r.addr[31:1], 1'b0};
      data_sram_wstrb = pos[1] ? 4'b1100 : 4'b0011;
      data_sram_wdata = {2{r.rt[15:0]}};
    end else if (r.st_op[1]) begin
      data_sram_wstrb = 4'b1111 >> (2'd3 - pos);
      data_sram_wdata = r.rt >> {(2'd3 - pos), 3'b000};
    end else if (r.st_op[0]) begin
      data_sram_wstrb = 4'b1111 << pos;
      data_sram_wdata = r.rt << {pos, 3'b000};
    end else begin
      data_sram_wstrb = 4'b1111;
      data_sram_wdata = r.rt;
    end
    if (!is_store) begin
      data_sram_wstrb = 4'b0000;
      data_sram_wdata = 32'h0;
    end
  end

  assign data_sram_wr = is_store;

  assign out_pc       = r.pc;
  assign out_addr     = r.addr;
  assign out_ld_op    = r.ld_op;
  assign out_store_op = is_store;
  assign out_ex       = ex;
  assign out_excode   = !ex      ? 5'h00 :
                        r.ex     ? r.excode :
                        is_store ? EXC_ADES : EXC_ADEL;
  assign out_badvaddr = addr_err ? r.addr : 32'h0;

endmodule

// File: tb/tb_es_mem_req.sv
// Directed bench for es_mem_req: request encoding, FSM handshakes, flush/cancel, reset.
module tb_es_mem_req;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_to_es_valid, es_allowin;
  logic [31:0] in_pc, in_addr, in_rt;
  logic [6:0]  in_ld_op;
  logic [4:0]  in_st_op;
  logic        in_ex;
  logic [4:0]  in_excode;
  logic        ms_allowin, es_to_ms_valid;
  logic [31:0] out_pc, out_addr, out_badvaddr;
  logic [6:0]  out_ld_op;
  logic        out_store_op, out_ex;
  logic [4:0]  out_excode;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, flush;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] LW = 7'b1000000, LB = 7'b0100000, LH = 7'b0001000;
  localparam logic [4:0] SW = 5'b10000, SB = 5'b01000, SWL = 5'b00010, SWR = 5'b00001;

  es_mem_req dut (
    .clk(clk), .resetn(resetn), .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .in_pc(in_pc), .in_addr(in_addr), .in_rt(in_rt), .in_ld_op(in_ld_op), .in_st_op(in_st_op),
    .in_ex(in_ex), .in_excode(in_excode), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
    .out_pc(out_pc), .out_addr(out_addr), .out_ld_op(out_ld_op), .out_store_op(out_store_op),
    .out_ex(out_ex), .out_excode(out_excode), .out_badvaddr(out_badvaddr),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one instruction for a single cycle, then drop ds_to_es_valid.
  task automatic issue(input logic [6:0] ld, input logic [4:0] st, input logic [31:0] addr,
                       input logic [31:0] rt, input logic ex, input logic [4:0] code);
    ds_to_es_valid = 1'b1; in_pc = addr ^ 32'hBFC0_0000; in_addr = addr; in_rt = rt;
    in_ld_op = ld; in_st_op = st; in_ex = ex; in_excode = code;
    tick();
    ds_to_es_valid = 1'b0;
    #1;
  endtask

  initial begin
    resetn = 1'b0; ds_to_es_valid = 1'b0; in_pc = '0; in_addr = '0; in_rt = '0;
    in_ld_op = '0; in_st_op = '0; in_ex = 1'b0; in_excode = '0;
    ms_allowin = 1'b1; data_sram_addr_ok = 1'b0; flush = 1'b0;
    #12;
    chk("rst_req", data_sram_req, 0);
    chk("rst_to_ms", es_to_ms_valid, 0);
    chk("rst_allowin", es_allowin, 1);
    chk("rst_pc", out_pc, 0);
    resetn = 1'b1;
    tick();

    // sw with addr_ok arriving on the third request cycle
    issue(7'b0, SW, 32'h1000_0004, 32'hAABB_CCDD, 1'b0, 5'h0);
    chk("sw_idle_noreq", data_sram_req, 0);
    chk("sw_idle_to_ms", es_to_ms_valid, 0);
    tick();
    chk("sw_req1", data_sram_req, 1);
    chk("sw_wstrb", data_sram_wstrb, 4'b1111);
    chk("sw_size", data_sram_size, 2);
    chk("sw_addr", data_sram_addr, 32'h1000_0004);
    chk("sw_wdata", data_sram_wdata, 32'hAABB_CCDD);
    chk("sw_wr", data_sram_wr, 1);
    chk("sw_allowin", es_allowin, 0);
    tick();
    chk("sw_req2", data_sram_req, 1);
    chk("sw_to_ms2", es_to_ms_valid, 0);
    tick();
    chk("sw_req3", data_sram_req, 1);
    chk("sw_addr3", data_sram_addr, 32'h1000_0004);
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0; #1;
    chk("sw_done_req", data_sram_req, 0);
    chk("sw_done_to_ms", es_to_ms_valid, 1);
    chk("sw_out_pc", out_pc, 32'hAFC0_0004);
    chk("sw_store_op", out_store_op, 1);
    tick();
    chk("sw_after_to_ms", es_to_ms_valid, 0);

    // sb byte lane 2
    issue(7'b0, SB, 32'h0000_0006, 32'h1122_3344, 1'b0, 5'h0);
    tick();
    chk("sb_req", data_sram_req, 1);
    chk("sb_wstrb", data_sram_wstrb, 4'b0100);
    chk("sb_wdata", data_sram_wdata, 32'h4444_4444);
    chk("sb_size", data_sram_size, 0);
    chk("sb_addr", data_sram_addr, 32'h0000_0006);
    data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0; #1;
    chk("sb_to_ms", es_to_ms_valid, 1);
    tick();

    // swr pos1
    issue(7'b0, SWR, 32'h0000_0105, 32'h1122_3344, 1'b0, 5'h0);
    tick();
    chk("swr_wstrb", data_sram_wstrb, 4'b1110);
    chk("swr_wdata", data_sram_wdata, 32'h2233_4400);
    chk("swr_addr", data_sram_addr, 32'h0000_0104);
    chk("swr_size", data_sram_size, 2);
    data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0; tick();

    // swl pos2
    issue(7'b0, SWL, 32'h0000_0206, 32'h1122_3344, 1'b0, 5'h0);
    tick();
    chk("swl_wstrb", data_sram_wstrb, 4'b0111);
    chk("swl_wdata", data_sram_wdata, 32'h0011_2233);
    chk("swl_addr", data_sram_addr, 32'h0000_0204);
    data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0; tick();

    // lb load: no strobes, read
    issue(LB, 5'b0, 32'h0000_0303, 32'hFFFF_FFFF, 1'b0, 5'h0);
    tick();
    chk("lb_wstrb", data_sram_wstrb, 4'b0000);
    chk("lb_wr", data_sram_wr, 0);
    chk("lb_size", data_sram_size, 0);
    chk("lb_addr", data_sram_addr, 32'h0000_0303);
    data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0; tick();

    // misaligned lh
    issue(LH, 5'b0, 32'h0000_0403, 32'h0, 1'b0, 5'h0);
`ifdef ES_ADDR_EXC_EN
    chk("lh_ade_noreq", data_sram_req, 0);
    chk("lh_ade_ex", out_ex, 1);
    chk("lh_ade_code", out_excode, 5'h04);
    chk("lh_ade_bad", out_badvaddr, 32'h0000_0403);
    chk("lh_ade_to_ms", es_to_ms_valid, 1);
    tick();
    chk("lh_ade_noreq2", data_sram_req, 0);
`else
    chk("lh_noex", out_ex, 0);
    chk("lh_bad0", out_badvaddr, 0);
    tick();
    chk("lh_req", data_sram_req, 1);
    chk("lh_addr_aligned", data_sram_addr, 32'h0000_0402);
    chk("lh_size", data_sram_size, 1);
    data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0; #1;
    chk("lh_to_ms", es_to_ms_valid, 1);
    tick();
`endif

    // upstream exception: no request, excode passed through
    issue(LW, 5'b0, 32'h0000_0502, 32'h0, 1'b1, 5'h0A);
    chk("upex_ex", out_ex, 1);
    chk("upex_code", out_excode, 5'h0A);
    chk("upex_to_ms", es_to_ms_valid, 1);
    tick();
    chk("upex_noreq", data_sram_req, 0);

    // flush in REQ without addr_ok -> CANCEL
    issue(LW, 5'b0, 32'h0000_0100, 32'h0, 1'b0, 5'h0);
    tick();
    chk("cx_req", data_sram_req, 1);
    flush = 1'b1; #1;
    chk("cx_flush_to_ms", es_to_ms_valid, 0);
    tick();
    flush = 1'b0;
    ds_to_es_valid = 1'b1; in_ld_op = 7'b0; in_st_op = 5'b0; in_pc = 32'h1234_5678; #1;
    chk("cx_req_held", data_sram_req, 1);
    chk("cx_allowin", es_allowin, 0);
    chk("cx_to_ms", es_to_ms_valid, 0);
    tick();
    chk("cx_allowin2", es_allowin, 0);
    chk("cx_pc_kept", out_pc, 32'hBFC0_0100);
    ds_to_es_valid = 1'b0;
    data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0; #1;
    chk("cx_idle_req", data_sram_req, 0);
    chk("cx_idle_allowin", es_allowin, 1);
    chk("cx_idle_to_ms", es_to_ms_valid, 0);
    tick();

    // flush together with addr_ok in REQ discards the instruction
    issue(LW, 5'b0, 32'h0000_0600, 32'h0, 1'b0, 5'h0);
    tick();
    flush = 1'b1; data_sram_addr_ok = 1'b1;
    tick();
    flush = 1'b0; data_sram_addr_ok = 1'b0; #1;
    chk("fa_req", data_sram_req, 0);
    chk("fa_to_ms", es_to_ms_valid, 0);
    tick();
    chk("fa_to_ms2", es_to_ms_valid, 0);

    // ms_allowin low holds off the request
    ms_allowin = 1'b0;
    issue(LW, 5'b0, 32'h0000_0200, 32'h0, 1'b0, 5'h0);
    tick();
    chk("ma_noreq1", data_sram_req, 0);
    tick();
    chk("ma_noreq2", data_sram_req, 0);
    ms_allowin = 1'b1; #1;
    chk("ma_noreq3", data_sram_req, 0);
    tick();
    chk("ma_req", data_sram_req, 1);
    chk("ma_addr", data_sram_addr, 32'h0000_0200);
    data_sram_addr_ok = 1'b1; tick(); data_sram_addr_ok = 1'b0; #1;
    chk("ma_to_ms", es_to_ms_valid, 1);
    tick();

    // non-memory instruction passes in one cycle
    issue(7'b0, 5'b0, 32'h0000_0000, 32'h0, 1'b0, 5'h0);
    chk("nm_to_ms", es_to_ms_valid, 1);
    chk("nm_noreq", data_sram_req, 0);
    tick();
    chk("nm_gone", es_to_ms_valid, 0);

    // asynchronous reset in the middle of REQ
    issue(7'b0, SW, 32'h0000_0700, 32'h5555_AAAA, 1'b0, 5'h0);
    tick();
    chk("ar_req", data_sram_req, 1);
    #2 resetn = 1'b0; #1;
    chk("ar_req0", data_sram_req, 0);
    chk("ar_allowin", es_allowin, 1);
    chk("ar_to_ms", es_to_ms_valid, 0);
    chk("ar_pc", out_pc, 0);
    resetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/es_mem_req.md
Name: es_mem_req

Overview:
- Memory-request issue unit of the execute stage, sitting directly upstream of the memory stage.
- Holds the EX pipeline register for load/store instructions and issues sram-like data requests (req/addr_ok).
- Generates size, byte strobes and aligned write data for sw/sb/sh/swl/swr, and address-error exceptions.
- Hands each instruction to the memory stage only after its address phase has completed, so the memory stage's data_ok ordering holds.

Parameters:
- EXC_ADEL, 5'h04, excode for load/fetch address error
- EXC_ADES, 5'h05, excode for store address error

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ds_to_es_valid  in  1  upstream instruction valid
- es_allowin  out  1  stage can accept
- in_pc  in  32  instruction PC
- in_addr  in  32  effective address (base+offset)
- in_rt  in  32  store source register value
- in_ld_op  in  7  one-hot {lw,lb,lbu,lh,lhu,lwl,lwr}
- in_st_op  in  5  one-hot {sw,sb,sh,swl,swr}
- in_ex  in  1  exception already raised upstream
- in_excode  in  5  upstream excode
- ms_allowin  in  1  memory stage can accept
- es_to_ms_valid  out  1  instruction valid to memory stage
- out_pc  out  32  registered PC
- out_addr  out  32  registered effective address (unaligned)
- out_ld_op  out  7  registered load op
- out_store_op  out  1  |st_op
- out_ex  out  1  exception flag
- out_excode  out  5  excode
- out_badvaddr  out  32  faulting address
- data_sram_req  out  1  request
- data_sram_wr  out  1  1 = store
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word
- data_sram_wstrb  out  4  byte enables
- data_sram_addr  out  32  request address
- data_sram_wdata  out  32  store data
- data_sram_addr_ok  in  1  address phase accepted
- flush  in  1  exception/eret flush from writeback

Behaviour:
- Reset: es_valid=0, state=IDLE, data_sram_req=0, es_to_ms_valid=0, all registered fields 0.
- Pipeline register:
  - es_allowin = (!es_valid || ready_go && ms_allowin) && state!=CANCEL.
  - Loaded when ds_to_es_valid && es_allowin.
  - flush clears es_valid the next cycle.
- mem_op = |ld_op || |st_op. ex = es_valid && (in_ex_r || addr_err).
- addr_err:
  - lw/sw: addr[1:0]!=0.
  - lh/lhu/sh: addr[0].
  - Excode is ADEL for loads, ADES for stores.
  - An upstream ex takes priority over addr_err.
  - out_badvaddr = addr on addr_err, else 0.
- State machine {IDLE, REQ, DONE, CANCEL}:
  - IDLE→REQ when es_valid && mem_op && !ex && !flush && ms_allowin.
  - data_sram_req = (state==REQ || state==CANCEL). It is not asserted in the IDLE cycle, so it is first asserted one cycle after the IDLE→REQ condition holds.
  - REQ: req held with constant addr/size/wstrb/wdata until addr_ok. On addr_ok: if flush in the same cycle → IDLE; else DONE.
  - REQ with flush and no addr_ok → CANCEL.
  - CANCEL: req held until addr_ok, then IDLE. No new instruction is accepted (es_allowin=0).
  - DONE→IDLE on es_to_ms_valid && ms_allowin, or on flush.
- ready_go = !mem_op || ex || state==DONE.
- es_to_ms_valid = es_valid && ready_go && !flush.
- Request encoding (pos = addr[1:0]):
  - sw/lw: size=2, wstrb=1111, wdata=rt.
  - sb/lb/lbu: size=0, wstrb=0001<<pos, wdata={4{rt[7:0]}}.
  - sh/lh/lhu: size=1, wstrb = pos[1] ? 1100 : 0011, wdata={2{rt[15:0]}}.
  - swl/lwl, swr/lwr: address forced to {addr[31:2],00}, size=2.
  - swl wstrb pos0..3: 0001, 0011, 0111, 1111. wdata: {24'b0,rt[31:24]}, {16'b0,rt[31:16]}, {8'b0,rt[31:8]}, rt.
  - swr wstrb pos0..3: 1111, 1110, 1100, 1000. wdata: rt, {rt[23:0],8'b0}, {rt[15:0],16'b0}, {rt[7:0],24'b0}.
  - Loads drive wstrb=0000 and wr=0.
  - Non-word byte/half requests use the unaligned address.
- Simultaneous events: addr_ok together with flush in REQ discards the instruction. The memory stage's cancel logic drops the resulting data_ok.

Optional Feature:
- ES_ADDR_EXC_EN.
- Defined: address-error detection as above; faulting accesses never assert req and pass to the memory stage with out_ex=1.
- Undefined: addr_err is tied 0. lw/sw addresses are forced to a word boundary, and lh/lhu/sh addresses to a half boundary. out_badvaddr=0.

Test Plan:
- sw addr 0x1000_0004 rt 0xAABBCCDD, addr_ok after 3 cycles → req held 3 cycles, wstrb=1111, size=2, then es_to_ms_valid=1 for 1 cycle.
- sb addr 0x...6, rt 0x11223344 → wstrb=0100, wdata=0x44444444, size=0; swr pos1 → wstrb=1110, wdata=0x22334400.
- lh addr 0x...3 with ES_ADDR_EXC_EN → no req, out_ex=1, out_excode=0x04, out_badvaddr=0x...3.
- flush while in REQ without addr_ok → state CANCEL, req held, es_allowin=0 until addr_ok, then IDLE, es_to_ms_valid never asserted.
- ms_allowin=0 with a pending lw → req not raised until ms_allowin=1; non-mem instruction passes in 1 cycle.
- resetn deasserted mid-REQ → req=0 and es_valid=0 immediately (asynchronous).
